// File: rtl/prog_loader_ctrl_if.sv
// -----------------------------------------------------------------------------
// prog_loader_ctrl_if
// Purpose : groups the loader's source stream and processor load port.
//   in_valid / in_word / in_ready          : source word stream (valid/ready)
//   new_instruction / load_we / add_into   : registered write port to the
//                                            processor instruction/data memory
// Modports:
//   master : environment side (drives the source stream, observes the load port)
//   slave  : controller side (accepts the stream, drives the load port)
// -----------------------------------------------------------------------------
interface prog_loader_ctrl_if;
    localparam int unsigned WORD_W = 32;

    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;
    logic [WORD_W-1:0] new_instruction;
    logic              load_we;
    logic              add_into;

    modport master (
        output in_valid,
        output in_word,
        input  in_ready,
        input  new_instruction,
        input  load_we,
        input  add_into
    );

    modport slave (
        input  in_valid,
        input  in_word,
        output in_ready,
        output new_instruction,
        output load_we,
        output add_into
    );
endinterface

// File: rtl/prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// prog_loader_ctrl
// Purpose : streams cfg_instr_len instruction words, then cfg_data_len data
//           words, into a processor load port, then runs the processor until
//           it reports completion.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   go                    : one-cycle start pulse (IDLE/DONE only, instr_len != 0)
//   cfg_instr_len/data_len: word counts captured on go
//   bus (slave modport)   : in_valid/in_word/in_ready source stream,
//                           new_instruction/load_we/add_into load port
//   start_signal          : processor run enable
//   end_signal            : processor program-complete
//   busy, done, timeout   : status (timeout is sticky until next go)
// Optional feature:
//   LOADER_TIMEOUT_EN     : when defined, RUN is bounded by TIMEOUT_CYCLES;
//                           otherwise there is no watchdog and timeout stays 0.
// -----------------------------------------------------------------------------
module prog_loader_ctrl #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [CNT_W-1:0]   cfg_instr_len,
    input  logic [CNT_W-1:0]   cfg_data_len,
    prog_loader_ctrl_if.slave  bus,
    output logic               start_signal,
    input  logic               end_signal,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_I = 3'd1;
    localparam logic [2:0] S_SWITCH = 3'd2;
    localparam logic [2:0] S_LOAD_D = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  instr_len_q, instr_len_d;
    logic [CNT_W-1:0]  data_len_q, data_len_d;
    logic [CNT_W-1:0]  instr_cnt, instr_cnt_d;
    logic [CNT_W-1:0]  data_cnt, data_cnt_d;
    logic [WORD_W-1:0] word_d;
    logic              load_we_d, add_into_d, in_ready_d;
    logic              start_d, busy_d, done_d, timeout_d;
    logic              accept_c;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]   run_cnt, run_cnt_d;
`endif

    // in_ready is registered from the next state, so it is high exactly in load states
    assign accept_c = bus.in_valid & bus.in_ready;

    // Next-state and registered-output values
    always_comb begin
        state_d     = state;
        instr_len_d = instr_len_q;
        data_len_d  = data_len_q;
        instr_cnt_d = instr_cnt;
        data_cnt_d  = data_cnt;
        word_d      = bus.new_instruction;
        load_we_d   = 1'b0;
        add_into_d  = bus.add_into;
        start_d     = start_signal;
        done_d      = done;
`ifdef LOADER_TIMEOUT_EN
        timeout_d   = timeout;
        run_cnt_d   = (state == S_RUN) ? run_cnt + TO_W'(1) : '0;
`else
        timeout_d   = 1'b0;
`endif

        case (state)
            S_IDLE, S_DONE: begin
                if (go && (cfg_instr_len != '0)) begin
                    instr_len_d = cfg_instr_len;
                    data_len_d  = cfg_data_len;
                    instr_cnt_d = '0;
                    data_cnt_d  = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    add_into_d  = 1'b0;
                    state_d     = S_LOAD_I;
                end
            end
            S_LOAD_I: begin
                if (accept_c) begin
                    word_d      = bus.in_word;
                    load_we_d   = 1'b1;
                    instr_cnt_d = instr_cnt + CNT_W'(1);
                    if (instr_cnt_d == instr_len_q) begin
                        state_d = S_SWITCH;
                    end
                end
            end
            // add_into rises at the end of SWITCH so the last instruction
            // strobe (visible during SWITCH) still carries add_into = 0
            S_SWITCH: begin
                add_into_d = 1'b1;
                if (data_len_q == '0) begin
                    start_d = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_LOAD_D;
                end
            end
            S_LOAD_D: begin
                if (accept_c) begin
                    word_d     = bus.in_word;
                    load_we_d  = 1'b1;
                    data_cnt_d = data_cnt + CNT_W'(1);
                    if (data_cnt_d == data_len_q) begin
                        start_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (end_signal) begin
                    start_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (run_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    start_d   = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD_I) || (state_d == S_LOAD_D);
        busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE));
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            instr_len_q         <= '0;
            data_len_q          <= '0;
            instr_cnt           <= '0;
            data_cnt            <= '0;
            bus.new_instruction <= '0;
            bus.load_we         <= 1'b0;
            bus.add_into        <= 1'b0;
            bus.in_ready        <= 1'b0;
            start_signal        <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            timeout             <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            run_cnt             <= '0;
`endif
        end else begin
            state               <= state_d;
            instr_len_q         <= instr_len_d;
            data_len_q          <= data_len_d;
            instr_cnt           <= instr_cnt_d;
            data_cnt            <= data_cnt_d;
            bus.new_instruction <= word_d;
            bus.load_we         <= load_we_d;
            bus.add_into        <= add_into_d;
            bus.in_ready        <= in_ready_d;
            start_signal        <= start_d;
            busy                <= busy_d;
            done                <= done_d;
            timeout             <= timeout_d;
`ifdef LOADER_TIMEOUT_EN
            run_cnt             <= run_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_loader_ctrl
// Purpose : self-checking bench for prog_loader_ctrl. Stimulus pushes the
//           expected {add_into, word} of every load strobe into a queue; a
//           negedge monitor pops and compares whenever load_we is high.
//           Status outputs are checked directly against hand-derived values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader_ctrl;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TO_CYC = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             go = 1'b0;
    logic             end_signal = 1'b0;
    logic [CNT_W-1:0] cfg_instr_len = '0;
    logic [CNT_W-1:0] cfg_data_len = '0;
    logic             start_signal, busy, done, timeout;

    prog_loader_ctrl_if lif ();

    prog_loader_ctrl #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .cfg_instr_len (cfg_instr_len),
        .cfg_data_len  (cfg_data_len),
        .bus           (lif),
        .start_signal  (start_signal),
        .end_signal    (end_signal),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_str_i = 0;
    int          n_str_d = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    // Strobe monitor: every load_we must match the next queued expectation
    always @(negedge clk) begin
        if (reset && lif.load_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected: got add_into=%0b word=0x%08h, required no strobe",
                         lif.add_into, lif.new_instruction);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({lif.add_into, lif.new_instruction} !== mon_exp) begin
                    n_err++;
                    $display("FAIL strobe_word: got add_into=%0b word=0x%08h, required add_into=%0b word=0x%08h",
                             lif.add_into, lif.new_instruction, mon_exp[32], mon_exp[31:0]);
                end
            end
            if (lif.add_into) n_str_d++;
            else              n_str_i++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},        32'(lif.in_ready),    32'd0);
        check({tag, "_load_we"},         32'(lif.load_we),     32'd0);
        check({tag, "_add_into"},        32'(lif.add_into),    32'd0);
        check({tag, "_new_instruction"}, lif.new_instruction,  32'd0);
        check({tag, "_start_signal"},    32'(start_signal),    32'd0);
        check({tag, "_busy"},            32'(busy),            32'd0);
        check({tag, "_done"},            32'(done),            32'd0);
        check({tag, "_timeout"},         32'(timeout),         32'd0);
    endtask

    task automatic pulse_go(input int il, input int dl);
        cfg_instr_len = CNT_W'(il);
        cfg_data_len  = CNT_W'(dl);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_end();
        end_signal = 1'b1;
        tick();
        end_signal = 1'b0;
    endtask

    // Present a word and hold it until the edge that accepts it (bounded)
    task automatic send_word(input logic [31:0] w, input logic add, input bit expect_strobe);
        int guard = 0;
        lif.in_valid = 1'b1;
        lif.in_word  = w;
        if (expect_strobe) exp_q.push_back({add, w});
        while (!lif.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!lif.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_wait: got in_ready=0 for 50 cycles, required 1");
        end else begin
            tick();
        end
    endtask

    int si, sd;

    initial begin
        lif.in_valid = 1'b0;
        lif.in_word  = '0;

        // Reset values while reset is held low
        #2;
        check_all_zero("reset");
        tick(2);
        reset = 1'b1;
        tick();
        check_all_zero("post_reset");

        // 3 instruction + 2 data words, back-to-back
        si = n_str_i; sd = n_str_d;
        pulse_go(3, 2);
        check("t1_in_ready", 32'(lif.in_ready), 32'd1);
        check("t1_busy",     32'(busy),         32'd1);
        send_word(32'h0000_1001, 1'b0, 1'b1);
        send_word(32'h0000_1002, 1'b0, 1'b1);
        send_word(32'h0000_1003, 1'b0, 1'b1);
        lif.in_valid = 1'b0;
        check("t1_switch_in_ready", 32'(lif.in_ready), 32'd0);
        check("t1_switch_add_into", 32'(lif.add_into), 32'd0);
        check("t1_switch_busy",     32'(busy),         32'd1);
        tick();
        check("t1_load_d_add_into", 32'(lif.add_into), 32'd1);
        check("t1_load_d_in_ready", 32'(lif.in_ready), 32'd1);
        send_word(32'h0000_2001, 1'b1, 1'b1);
        send_word(32'h0000_2002, 1'b1, 1'b1);
        lif.in_valid = 1'b0;
        check("t1_run_start",    32'(start_signal), 32'd1);
        check("t1_run_in_ready", 32'(lif.in_ready), 32'd0);
        check("t1_run_add_into", 32'(lif.add_into), 32'd1);
        tick();
        check("t1_instr_strobes", 32'(n_str_i - si), 32'd3);
        check("t1_data_strobes",  32'(n_str_d - sd), 32'd2);

        // go during RUN is ignored; end_signal ends the run
        pulse_go(1, 0);
        check("t1_go_in_run_start", 32'(start_signal), 32'd1);
        check("t1_go_in_run_busy",  32'(busy),         32'd1);
        tick(2);
        pulse_end();
        check("t1_end_start", 32'(start_signal), 32'd0);
        check("t1_end_done",  32'(done),         32'd1);
        check("t1_end_busy",  32'(busy),         32'd0);

        // end_signal and zero-length go are ignored in DONE
        pulse_end();
        check("done_end_ignored", 32'(done), 32'd1);
        pulse_go(0, 3);
        check("go_len0_done", 32'(done), 32'd1);
        check("go_len0_busy", 32'(busy), 32'd0);

        // Restart with instr_len=1, data_len=0: SWITCH goes straight to RUN
        sd = n_str_d;
        pulse_go(1, 0);
        check("t2_add_into", 32'(lif.add_into), 32'd0);
        check("t2_done",     32'(done),         32'd0);
        check("t2_busy",     32'(busy),         32'd1);
        send_word(32'h0000_0033, 1'b0, 1'b1);
        lif.in_valid = 1'b0;
        check("t2_switch_in_ready", 32'(lif.in_ready), 32'd0);
        check("t2_switch_start",    32'(start_signal), 32'd0);
        tick();
        check("t2_run_start",    32'(start_signal), 32'd1);
        check("t2_run_add_into", 32'(lif.add_into), 32'd1);
`ifdef LOADER_TIMEOUT_EN
        tick(TO_CYC - 1);
        check("t2_pre_timeout_start", 32'(start_signal), 32'd1);
        check("t2_pre_timeout_flag",  32'(timeout),      32'd0);
        tick();
        check("t2_timeout_flag",  32'(timeout),      32'd1);
        check("t2_timeout_done",  32'(done),         32'd1);
        check("t2_timeout_start", 32'(start_signal), 32'd0);
`else
        tick(TO_CYC + 4);
        check("t2_no_wdog_start",   32'(start_signal), 32'd1);
        check("t2_no_wdog_timeout", 32'(timeout),      32'd0);
        pulse_end();
        check("t2_end_done", 32'(done), 32'd1);
`endif
        check("t2_data_strobes", 32'(n_str_d - sd), 32'd0);

        // in_valid 1,0,0,1 in LOAD_I with words 0xA, 0xB
        si = n_str_i;
        pulse_go(2, 0);
        check("t3_timeout_cleared", 32'(timeout), 32'd0);
        lif.in_valid = 1'b1;
        lif.in_word  = 32'h0000_000A;
        exp_q.push_back({1'b0, 32'h0000_000A});
        tick();
        lif.in_valid = 1'b0;
        lif.in_word  = 32'h0000_00FF;
        tick(2);
        check("t3_gap_load_we", 32'(lif.load_we),   32'd0);
        check("t3_gap_word",    lif.new_instruction, 32'h0000_000A);
        check("t3_gap_in_ready", 32'(lif.in_ready), 32'd1);
        lif.in_valid = 1'b1;
        lif.in_word  = 32'h0000_000B;
        exp_q.push_back({1'b0, 32'h0000_000B});
        tick();
        lif.in_valid = 1'b0;
        check("t3_switch_in_ready", 32'(lif.in_ready), 32'd0);
        tick(2);
        check("t3_instr_strobes", 32'(n_str_i - si), 32'd2);
        check("t3_run_start", 32'(start_signal), 32'd1);
        pulse_end();

        // go while busy, then asynchronous reset after 2 of 4 words
        pulse_go(4, 1);
        send_word(32'h0000_4001, 1'b0, 1'b1);
        lif.in_valid = 1'b0;
        pulse_go(1, 0);
        check("t4_go_busy_in_ready", 32'(lif.in_ready), 32'd1);
        check("t4_go_busy_busy",     32'(busy),         32'd1);
        check("t4_go_busy_add_into", 32'(lif.add_into), 32'd0);
        send_word(32'h0000_4002, 1'b0, 1'b0);
        check("t4_pre_reset_load_we", 32'(lif.load_we),   32'd1);
        check("t4_pre_reset_word",    lif.new_instruction, 32'h0000_4002);
        reset = 1'b0;
        #1;
        check_all_zero("t4_async_reset");
        lif.in_valid = 1'b0;
        tick(2);
        reset = 1'b1;
        tick();
        check("t4_post_load_we",  32'(lif.load_we),  32'd0);
        check("t4_post_in_ready", 32'(lif.in_ready), 32'd0);
        check("t4_post_busy",     32'(busy),         32'd0);

        // Maximum length: 255 instruction words without counter wrap
        si = n_str_i; sd = n_str_d;
        pulse_go(255, 1);
        for (int i = 0; i < 255; i++) begin
            send_word(32'h5000_0000 + 32'(i), 1'b0, 1'b1);
        end
        lif.in_valid = 1'b0;
        check("t5_switch_in_ready", 32'(lif.in_ready), 32'd0);
        check("t5_switch_busy",     32'(busy),         32'd1);
        send_word(32'h0000_D00D, 1'b1, 1'b1);
        lif.in_valid = 1'b0;
        check("t5_run_start", 32'(start_signal), 32'd1);
        tick();
        check("t5_instr_strobes", 32'(n_str_i - si), 32'd255);
        check("t5_data_strobes",  32'(n_str_d - sd), 32'd1);
        pulse_end();
        check("t5_done", 32'(done), 32'd1);

        tick(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader_ctrl.md
PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the length configuration inputs and word counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: RUN-phase watchdog limit, used only with LOADER_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port go  input  1  one-cycle pulse that starts a load-and-run sequence.
REQ-006 SHALL have port cfg_instr_len  input  CNT_W  number of instruction words to load.
REQ-007 SHALL have port cfg_data_len  input  CNT_W  number of data words to load.
REQ-008 SHALL have port in_valid  input  1  source word valid.
REQ-009 SHALL have port in_word  input  32  source word.
REQ-010 SHALL have port in_ready  output  1  controller accepts in_word this cycle.
REQ-011 SHALL have port new_instruction  output  32  registered word driven to the processor load port.
REQ-012 SHALL have port load_we  output  1  one-cycle write strobe qualifying new_instruction.
REQ-013 SHALL have port add_into  output  1  memory select: 0 = instruction memory, 1 = data memory.
REQ-014 SHALL have port start_signal  output  1  processor run enable.
REQ-015 SHALL have port end_signal  input  1  processor program-complete indication.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-017 SHALL have port done  output  1  high in DONE.
REQ-018 SHALL have port timeout  output  1  sticky watchdog flag.

Function
REQ-019 SHALL implement the states IDLE, LOAD_I, SWITCH, LOAD_D, RUN and DONE.
REQ-020 SHALL, in IDLE or DONE, on go with cfg_instr_len nonzero, capture both lengths, clear the counters, done and timeout, and enter LOAD_I.
REQ-021 SHALL ignore go when cfg_instr_len is 0, and SHALL ignore go in all other states.
REQ-022 SHALL drive in_ready high only in LOAD_I and LOAD_D.
REQ-023 SHALL, on each accepted word (in_valid and in_ready), register in_word onto new_instruction, pulse load_we for exactly the following cycle, and increment the active counter.
REQ-024 SHALL, after accepting instruction word cfg_instr_len, enter SWITCH for exactly one cycle, during which add_into rises to 1.
REQ-025 SHALL go from SWITCH to LOAD_D, or directly to RUN when the captured data length is 0.
REQ-026 SHALL, after accepting data word cfg_data_len, enter RUN.
REQ-027 SHALL assert start_signal on the first RUN cycle and hold it until end_signal is sampled high.
REQ-028 SHALL, on end_signal in RUN, deassert start_signal and enter DONE.
REQ-029 SHALL ignore end_signal outside RUN.
REQ-030 SHALL not change new_instruction, add_into or state when in_valid is low during a load state.
REQ-031 SHALL keep add_into at 1 through RUN and DONE, and SHALL return it to 0 on entry to LOAD_I.
REQ-032 SHALL compare the counters at full CNT_W width, so a length of 2^CNT_W-1 loads exactly that many words without wrap.

Reset
REQ-033 SHALL, on reset low, immediately force state IDLE; in_ready, load_we, add_into, start_signal, busy, done and timeout to 0; new_instruction and both counters to 0.
REQ-034 SHALL, when reset is asserted mid-load or mid-run, abandon the sequence and leave no partial strobe after release.

Configuration
REQ-035 SHALL, with LOADER_TIMEOUT_EN defined, count RUN cycles and, on reaching TIMEOUT_CYCLES without end_signal, deassert start_signal, set timeout, and enter DONE.
REQ-036 SHALL, without LOADER_TIMEOUT_EN, contain no watchdog counter, tie timeout to 0, and wait in RUN indefinitely.

Verification
REQ-037 SHALL show that instr_len=3 and data_len=2 streamed back-to-back produce 3 load_we pulses with add_into=0, one SWITCH cycle, 2 pulses with add_into=1, and then start_signal=1.
REQ-038 SHALL show that data_len=0 goes SWITCH -> RUN, with zero load_we pulses at add_into=1.
REQ-039 SHALL show that in_valid toggling 1,0,0,1 in LOAD_I with words 0xA, 0xB yields exactly 2 strobes carrying 0xA then 0xB.
REQ-040 SHALL show that end_signal pulsed 5 cycles into RUN drops start_signal the next edge and raises done; a later go with instr_len=1 restarts with add_into=0.
REQ-041 SHALL show that reset pulsed low after 2 of 4 instruction words returns all outputs to 0 asynchronously, and that go while busy has no effect.
REQ-042 SHALL show that with LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, end_signal held low gives timeout=1, done=1 and start_signal=0 after 16 RUN cycles.
